hu_audiodec_wr_packer64: RTL and testbench
==========================================

# hu_audiodec_wr_packer64

Write-side packing stage for the audio decoder accelerator's 64-bit DMA path. It sits between the decoder core's 32-bit output sample stream and the ESP `dma_write_ctrl` / `dma_write_chnl` interfaces. On `start` it issues one write-control request for the whole transfer. It then packs pairs of 32-bit samples into 64-bit beats, zero-pads an odd final sample, and pulses `done` after the last beat is accepted.

## Interface
Parameters:
- `SAMPLE_W`, 32: input sample width; fixed at 32.
- `BEAT_W`, 64: DMA beat width; fixed at 64 (2 samples per beat).

Ports:
- Clocking: one clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a transfer; ignored unless IDLE.
- `cfg_base_index`  in  32  destination index, in 64-bit words.
- `cfg_num_samples`  in  32  number of 32-bit samples to write.
- `in_val`  in  1  sample stream valid.
- `in_rdy`  out  1  sample stream ready.
- `in_data`  in  32  sample.
- `dma_write_ctrl_valid`  out  1  write request valid.
- `dma_write_ctrl_ready`  in  1  write request accepted.
- `dma_write_ctrl_data_index`  out  32  latched `cfg_base_index`.
- `dma_write_ctrl_data_length`  out  32  beat count, ceil(num_samples/2).
- `dma_write_ctrl_data_size`  out  3  constant 3'b011 (64-bit).
- `dma_write_chnl_valid`  out  1  beat valid.
- `dma_write_chnl_ready`  in  1  beat accepted.
- `dma_write_chnl_data`  out  64  packed beat.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CTRL, DATA, DONE.
- IDLE, `start`=1:
  - Latch index, `rem_samples`=cfg_num_samples, and `length`=(cfg_num_samples+1)>>1. Compute this in 33 bits and truncate to 32; 0xFFFFFFFF gives 0x80000000.
  - Go to DONE if num_samples==0, else go to CTRL.
- CTRL: `dma_write_ctrl_valid`=1, with index, length and size held stable. On `ctrl_valid & ctrl_ready`, go to DATA.
- DATA:
  - Samples are accepted on `in_val & in_rdy`.
  - The first sample of a pair goes to the half register (bits [31:0]). The second forms the beat {sample, half} into the output register.
  - If the accepted sample is the last one (`rem_samples`==1) and the half register is empty, the beat {32'h0, sample} is formed immediately.
- `in_rdy` = DATA & rem_samples≠0 & (slot_free | (~half_valid & rem_samples>1)).
  - slot_free = ~chnl_valid | chnl_ready.
- DATA → DONE on the handshake of the final beat, i.e. rem_samples==0, no half pending, and `chnl_valid & chnl_ready`.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE has no effect.
- No chunking: the entire transfer is a single control request.

## Timing
- Reset values:
  - All valid outputs, `in_rdy` and `done` are 0.
  - The data, index and length registers are 0. `size` is always 3'b011.
  - State is IDLE, the half register is empty, and `rem_samples` is 0.
- Reset mid-transfer: all outputs return to their reset values immediately, asynchronously. Partial beats are discarded.
- `start` at cycle t gives `ctrl_valid` at t+1. For num_samples==0, `done` is at t+1 and `ctrl_valid` is never asserted.
- `in_rdy` is first high in the cycle after the ctrl handshake.
- A sample accepted at t that completes a beat gives `chnl_valid` at t+1.
- Sustained throughput: 1 sample/cycle in and 1 beat per 2 cycles out, with no bubbles when `chnl_ready`=1.
- Handshakes: once a valid is asserted, payload and valid are held until ready. `ctrl_ready` or `chnl_ready` seen without valid is ignored.
- Backpressure: with the output register full and `chnl_ready`=0, one further sample may still be accepted into the half register, except the last sample.
- `done` is asserted the cycle after the final beat handshake.

## Structure
- Shared package `hu_audiodec_dma_pkg`:
  - `DMA_SIZE_DWORD`=3'b011 and beat/sample width constants.
  - Packer state enum {IDLE, CTRL, DATA, DONE}.
  - Reusable by the read-side unpacker.
- Single module. There is no natural sub-module; the half/output register pair is inline.
- Target size: about 150–250 lines of RTL.

## Test plan
- base=0x100, n=4, samples 0x11,0x22,0x33,0x44, ready tied 1:
  - ctrl index=0x100, length=2, size=3.
  - Beats 0x00000022_00000011 then 0x00000044_00000033.
  - `done` one cycle after beat 2.
- n=3, samples 0xA,0xB,0xC: length=2; second beat is 0x00000000_0000000C.
- n=0: no ctrl_valid and no chnl_valid; `done` at t+1.
- n=8, `chnl_ready` toggling 1-0-0-1 and `ctrl_ready` delayed 5 cycles:
  - Payloads stay stable while stalled.
  - No sample is accepted before the ctrl handshake.
  - All 4 beats arrive in order.
- Reset asserted after 1 beat of an n=6 transfer: outputs return to 0 immediately. A new start with n=2 then produces a clean, correct transfer.
- `start` pulsed during DATA with different cfg: no effect; the original length and data complete.

Source files
------------

// File: rtl/hu_audiodec_dma_pkg.sv
// Shared constants and types for the audio decoder 64-bit DMA pack/unpack stages.
package hu_audiodec_dma_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;
    localparam int unsigned BEAT_WIDTH   = 64;

    // ESP dma size encoding for 64-bit words
    localparam logic [2:0] DMA_SIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StCtrl,
        StData,
        StDone
    } packer_state_e;

endpackage

// File: rtl/hu_audiodec_wr_packer64.sv
// Packs 32-bit decoder samples into 64-bit DMA write beats behind a single write-control request.
module hu_audiodec_wr_packer64
    import hu_audiodec_dma_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_WIDTH,
    parameter int unsigned BEAT_W   = BEAT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         cfg_base_index,
    input  logic [31:0]         cfg_num_samples,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                dma_write_ctrl_valid,
    input  logic                dma_write_ctrl_ready,
    output logic [31:0]         dma_write_ctrl_data_index,
    output logic [31:0]         dma_write_ctrl_data_length,
    output logic [2:0]          dma_write_ctrl_data_size,
    output logic                dma_write_chnl_valid,
    input  logic                dma_write_chnl_ready,
    output logic [BEAT_W-1:0]   dma_write_chnl_data,
    output logic                done
);

    packer_state_e state_q, state_d;

    logic [31:0]         rem_q, rem_d;
    logic [31:0]         index_q, index_d;
    logic [31:0]         length_q, length_d;
    logic [SAMPLE_W-1:0] half_q, half_d;
    logic                half_valid_q, half_valid_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                beat_valid_q, beat_valid_d;

    logic [32:0] length_sum;
    logic        slot_free;
    logic        in_fire;
    logic        ctrl_fire;
    logic        beat_fire;

    // Beat count rounds up; the 33-bit sum keeps 0xFFFFFFFF from wrapping to 0.
    assign length_sum = {1'b0, cfg_num_samples} + 33'd1;
    assign slot_free  = ~beat_valid_q | dma_write_chnl_ready;
    assign in_fire    = in_val & in_rdy;
    assign ctrl_fire  = dma_write_ctrl_valid & dma_write_ctrl_ready;
    assign beat_fire  = beat_valid_q & dma_write_chnl_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            index_q      <= '0;
            length_q     <= '0;
            half_q       <= '0;
            half_valid_q <= 1'b0;
            beat_q       <= '0;
            beat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            index_q      <= index_d;
            length_q     <= length_d;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            beat_q       <= beat_d;
            beat_valid_q <= beat_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (cfg_num_samples == '0) ? StDone : StCtrl;
                end
            end
            StCtrl: begin
                if (ctrl_fire) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (rem_q == '0 && !half_valid_q && beat_fire) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dma_write_ctrl_valid = (state_q == StCtrl);
        done                 = (state_q == StDone);
        // One extra sample may park in the half register while the beat slot is blocked,
        // but never the last one, which must go straight into a beat.
        in_rdy = (state_q == StData) && (rem_q != '0) &&
                 (slot_free || (!half_valid_q && rem_q > 32'd1));
    end

    always_comb begin
        rem_d        = rem_q;
        index_d      = index_q;
        length_d     = length_q;
        half_d       = half_q;
        half_valid_d = half_valid_q;
        beat_d       = beat_q;
        beat_valid_d = beat_valid_q & ~beat_fire;

        if (state_q == StIdle && start) begin
            index_d  = cfg_base_index;
            length_d = length_sum[32:1];
            rem_d    = cfg_num_samples;
        end

        if (in_fire) begin
            rem_d = rem_q - 32'd1;
            if (half_valid_q) begin
                beat_d       = {in_data, half_q};
                beat_valid_d = 1'b1;
                half_valid_d = 1'b0;
            end else if (rem_q == 32'd1) begin
                beat_d       = {{SAMPLE_W{1'b0}}, in_data};
                beat_valid_d = 1'b1;
            end else begin
                half_d       = in_data;
                half_valid_d = 1'b1;
            end
        end
    end

    assign dma_write_ctrl_data_index  = index_q;
    assign dma_write_ctrl_data_length = length_q;
    assign dma_write_ctrl_data_size   = DMA_SIZE_DWORD;
    assign dma_write_chnl_valid       = beat_valid_q;
    assign dma_write_chnl_data        = beat_q;

endmodule

// File: tb/tb_hu_audiodec_wr_packer64.sv
// Directed bench for the 64-bit write packer: ctrl request, packing, padding, stalls, reset.
module tb_hu_audiodec_wr_packer64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_base_index;
    logic [31:0] cfg_num_samples;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_valid;
    logic        dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] samp [0:7];
    logic [63:0] beat [0:3];
    bit          pat  [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

    hu_audiodec_wr_packer64 dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .cfg_base_index             (cfg_base_index),
        .cfg_num_samples            (cfg_num_samples),
        .in_val                     (in_val),
        .in_rdy                     (in_rdy),
        .in_data                    (in_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .done                       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rdy"}, in_rdy, 0);
        check({tag, "_ctrl_valid"}, dma_write_ctrl_valid, 0);
        check({tag, "_index"}, dma_write_ctrl_data_index, 0);
        check({tag, "_length"}, dma_write_ctrl_data_length, 0);
        check({tag, "_size"}, dma_write_ctrl_data_size, 3'b011);
        check({tag, "_chnl_valid"}, dma_write_chnl_valid, 0);
        check({tag, "_chnl_data"}, dma_write_chnl_data, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Runs one transfer against samp[]/beat[]; poke_cyc re-pulses start mid-transfer,
    // abort_beats asserts reset once that many beats have been accepted.
    task automatic run_xfer(input logic [31:0] base, input int n, input logic [31:0] exp_len,
                            input int ctrl_delay, input bit stall, input int poke_cyc,
                            input int abort_beats);
        int cyc = 0;
        int k = 0;
        int idx = 0;
        int last_beat_cyc = -1;
        int nbeats = (n + 1) / 2;
        bit ctrl_hs = 1'b0;
        bit aborted = 1'b0;
        @(negedge clk);
        cfg_base_index  = base;
        cfg_num_samples = n;
        start           = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (1) begin
            if (abort_beats != 0 && k >= abort_beats) begin
                rst    = 1'b0;
                in_val = 1'b0;
                #1;
                check_reset_outputs("abort");
                aborted = 1'b1;
                break;
            end
            start = (cyc == poke_cyc);
            if (start) begin
                cfg_base_index  = 32'h999;
                cfg_num_samples = 32'd10;
            end
            dma_write_ctrl_ready = (cyc > ctrl_delay);
            dma_write_chnl_ready = stall ? pat[cyc % 4] : 1'b1;
            in_val  = (idx < n);
            in_data = (idx < n) ? samp[idx] : 32'h0;
            #1;
            if (cyc == 1) check("ctrl_valid_t1", dma_write_ctrl_valid, n != 0);
            if (dma_write_ctrl_valid) begin
                check("ctrl_index", dma_write_ctrl_data_index, base);
                check("ctrl_length", dma_write_ctrl_data_length, exp_len);
                check("ctrl_size", dma_write_ctrl_data_size, 3'b011);
                check("ctrl_once", ctrl_hs, 0);
                if (dma_write_ctrl_ready) ctrl_hs = 1'b1;
            end
            if (in_rdy) check("rdy_after_ctrl", ctrl_hs, 1);
            if (in_val && in_rdy) idx++;
            if (dma_write_chnl_valid) begin
                check("beat_in_range", k < nbeats, 1);
                if (k < nbeats) check($sformatf("beat%0d", k), dma_write_chnl_data, beat[k]);
                if (dma_write_chnl_ready) begin
                    k++;
                    last_beat_cyc = cyc;
                end
            end
            if (done) begin
                check("beat_count", k, nbeats);
                check("done_latency", cyc, (n == 0) ? 1 : last_beat_cyc + 1);
                check("samples_taken", idx, n);
                break;
            end
            if (cyc >= 300) begin
                check("timeout", 1, 0);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start  = 1'b0;
        in_val = 1'b0;
        if (!aborted) begin
            @(negedge clk);
            #1;
            check("done_pulse", done, 0);
            check("idle_ctrl", dma_write_ctrl_valid, 0);
        end
    endtask

    initial begin
        rst                  = 1'b0;
        start                = 1'b0;
        cfg_base_index       = '0;
        cfg_num_samples      = '0;
        in_val               = 1'b0;
        in_data              = '0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Even count, ready tied high
        samp[0] = 32'h11; samp[1] = 32'h22; samp[2] = 32'h33; samp[3] = 32'h44;
        beat[0] = 64'h00000022_00000011;
        beat[1] = 64'h00000044_00000033;
        run_xfer(32'h100, 4, 32'd2, 0, 1'b0, 0, 0);

        // Odd count pads the final beat
        samp[0] = 32'hA; samp[1] = 32'hB; samp[2] = 32'hC;
        beat[0] = 64'h0000000B_0000000A;
        beat[1] = 64'h00000000_0000000C;
        run_xfer(32'h200, 3, 32'd2, 0, 1'b0, 0, 0);

        // Empty transfer
        run_xfer(32'h300, 0, 32'd0, 0, 1'b0, 0, 0);

        // Delayed ctrl ready and toggling chnl ready
        for (int i = 0; i < 8; i++) samp[i] = 32'h101 + i;
        beat[0] = 64'h00000102_00000101;
        beat[1] = 64'h00000104_00000103;
        beat[2] = 64'h00000106_00000105;
        beat[3] = 64'h00000108_00000107;
        run_xfer(32'h400, 8, 32'd4, 5, 1'b1, 0, 0);

        // Reset after the first beat, then a clean short transfer
        for (int i = 0; i < 6; i++) samp[i] = 32'h1 + i;
        beat[0] = 64'h00000002_00000001;
        run_xfer(32'h600, 6, 32'd3, 0, 1'b0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        samp[0] = 32'h55; samp[1] = 32'h66;
        beat[0] = 64'h00000066_00000055;
        run_xfer(32'h500, 2, 32'd1, 0, 1'b0, 0, 0);

        // start during DATA is ignored
        samp[0] = 32'h71; samp[1] = 32'h72; samp[2] = 32'h73; samp[3] = 32'h74;
        beat[0] = 64'h00000072_00000071;
        beat[1] = 64'h00000074_00000073;
        run_xfer(32'h700, 4, 32'd2, 0, 1'b0, 3, 0);

        // Length rounding at the 32-bit limit
        @(negedge clk);
        cfg_base_index       = 32'h800;
        cfg_num_samples      = 32'hFFFF_FFFF;
        dma_write_ctrl_ready = 1'b0;
        start                = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("max_ctrl_valid", dma_write_ctrl_valid, 1);
        check("max_length", dma_write_ctrl_data_length, 32'h8000_0000);
        check("max_index", dma_write_ctrl_data_index, 32'h800);
        rst = 1'b0;
        #1;
        check_reset_outputs("max_abort");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
